parameter_word_serializer: RTL and testbench
============================================

// Module: parameter_word_serializer
// PURPOSE
//  Packs one of two wide MICROROC parameter images (slow-control or read-scope) into
//  WORD_WIDTH-bit words, MSB first, and writes them into the external FIFO that feeds
//  the bit-shift engine. Honours FIFO back-pressure and reports progress and completion.
//  Sits between the parameter register bank and the external parameter FIFO.
// PARAMETERS
//  SC_WIDTH    592  slow-control image width in bits
//  RS_WIDTH    64   read-scope image width in bits
//  WORD_WIDTH  16   FIFO word width in bits
//  (derived) SC_WORDS = ceil(SC_WIDTH/WORD_WIDTH), RS_WORDS = ceil(RS_WIDTH/WORD_WIDTH)
//  (derived) CW = $clog2(max(SC_WORDS,RS_WORDS)+1)
// PORTS
//  Clk           in   1            system clock; only clock
//  reset         in   1            synchronous, active-high reset
//  Start         in   1            request to serialize; sampled only in IDLE
//  ModeSelect    in   1            0 = slow-control image, 1 = read-scope image; sampled with Start
//  ScParameters  in   SC_WIDTH     slow-control image, bit SC_WIDTH-1 shifted first
//  RsParameters  in   RS_WIDTH     read-scope image, bit RS_WIDTH-1 shifted first
//  FifoFull      in   1            external FIFO full; no write while high
//  FifoWriteEn   out  1            write strobe; a word is written at each edge where it is high
//  FifoData      out  WORD_WIDTH   word being written
//  Busy          out  1            high from LOAD through DONE inclusive
//  Done          out  1            one-cycle pulse after the last word is written
//  WordCount     out  CW           words written in the current or last transfer
// BEHAVIOUR
//  Reset: state=IDLE; FifoWriteEn=0, FifoData=0, Busy=0, Done=0, WordCount=0;
//   shift register cleared.
//  States: IDLE -> LOAD -> WRITE -> DONE -> IDLE.
//  IDLE: on Start=1, latch ModeSelect, go to LOAD. Start is ignored in every other state.
//  LOAD (1 cycle): selected image goes into a shift register of width
//   max(SC_WORDS,RS_WORDS)*WORD_WIDTH. The image is MSB-aligned. Unused low bits are zero,
//   so a partial final word is zero-padded on its LSB side.
//   WordCount is cleared; target N = SC_WORDS or RS_WORDS.
//  WRITE: FifoWriteEn = (state==WRITE) && !FifoFull (combinational).
//   FifoData = top WORD_WIDTH bits of the shift register (registered).
//   On each edge with FifoWriteEn=1: shift left by WORD_WIDTH, zero-fill, WordCount+1.
//   When the write that brings WordCount to N is accepted, go to DONE.
//  FifoFull=1: no write; FifoData holds its value; the word is retried when FifoFull falls.
//  DONE (1 cycle): Done=1, FifoWriteEn=0; then IDLE. WordCount holds N until the next LOAD.
//  Timing with no back-pressure:
//   - Start seen at edge k -> LOAD in cycle k..k+1.
//   - FifoWriteEn high for cycles k+1..k+N (N consecutive writes).
//   - Done high for 1 cycle, in cycle k+N+1.
//  reset mid-transfer: IDLE next cycle, FifoWriteEn=0 immediately at that edge.
//   No partial Done. Words already written stay in the FIFO.
//  Images are sampled only in LOAD; later input changes do not affect the transfer.
// TESTING
//  1 Defaults, ModeSelect=0, Sc[591:576]=16'hFA5E, FifoFull=0, Start pulse
//    -> 37 consecutive writes, first word 16'hFA5E, Done 1 cycle after 37th, WordCount=37.
//  2 ModeSelect=1, Rs=64'h0123_4567_89AB_CDEF
//    -> exactly 4 writes: 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF; Done once.
//  3 RS image, FifoFull forced high for 5 cycles after the 2nd write
//    -> no FifoWriteEn while full, FifoData stable at 16'h89AB, transfer finishes with 4 words.
//  4 SC_WIDTH=20, Sc=20'hABCDE
//    -> 2 writes: 16'hABCD then 16'hE000.
//  5 Start re-pulsed during WRITE, and ModeSelect toggled during WRITE
//    -> ignored; word count and data unchanged; a single Done.
//  6 reset asserted after the 10th SC write
//    -> IDLE next edge, FifoWriteEn=0, Busy=0, WordCount=0, no Done;
//       a new Start then completes a full 37-word transfer.

Source files
------------

// File: rtl/parameter_word_serializer_if.sv
// Handshake and FIFO-side signals of the parameter word serializer.
// The serializer uses the master modport; the driving environment uses slave.
interface parameter_word_serializer_if #(
    parameter int SC_WIDTH   = 592,
    parameter int RS_WIDTH   = 64,
    parameter int WORD_WIDTH = 16
);
    localparam int SC_WORDS  = (SC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int RS_WORDS  = (RS_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int MAX_WORDS = (SC_WORDS > RS_WORDS) ? SC_WORDS : RS_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic                  Start;
    logic                  ModeSelect;
    logic                  FifoFull;
    logic                  FifoWriteEn;
    logic [WORD_WIDTH-1:0] FifoData;
    logic                  Busy;
    logic                  Done;
    logic [CW-1:0]         WordCount;

    modport master (
        input  Start, ModeSelect, FifoFull,
        output FifoWriteEn, FifoData, Busy, Done, WordCount
    );

    modport slave (
        output Start, ModeSelect, FifoFull,
        input  FifoWriteEn, FifoData, Busy, Done, WordCount
    );
endinterface

// File: rtl/parameter_word_serializer.sv
// Packs the slow-control or read-scope parameter image into FIFO words, MSB first,
// honouring FIFO back-pressure and reporting progress and completion.
module parameter_word_serializer #(
    parameter int SC_WIDTH   = 592,
    parameter int RS_WIDTH   = 64,
    parameter int WORD_WIDTH = 16
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic [SC_WIDTH-1:0] ScParameters,
    input  logic [RS_WIDTH-1:0] RsParameters,
    parameter_word_serializer_if.master bus
);
    localparam int SC_WORDS  = (SC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int RS_WORDS  = (RS_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int MAX_WORDS = (SC_WORDS > RS_WORDS) ? SC_WORDS : RS_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);
    localparam int SR_WIDTH  = MAX_WORDS * WORD_WIDTH;

    localparam logic [CW-1:0] SC_TARGET = CW'(SC_WORDS);
    localparam logic [CW-1:0] RS_TARGET = CW'(RS_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic                  mode;
    logic [SR_WIDTH-1:0]   shift_reg;
    logic [WORD_WIDTH-1:0] data;
    logic [CW-1:0]         word_count;

    logic [SR_WIDTH-1:0]   sc_aligned;
    logic [SR_WIDTH-1:0]   rs_aligned;
    logic [SR_WIDTH-1:0]   selected_image;
    logic [SR_WIDTH-1:0]   shifted;
    logic [CW-1:0]         target_words;
    logic [CW-1:0]         next_count;
    logic                  write_en;

    // Images are MSB-aligned so a short final word comes out zero-padded on its LSB side.
    assign sc_aligned     = SR_WIDTH'(ScParameters) << (SR_WIDTH - SC_WIDTH);
    assign rs_aligned     = SR_WIDTH'(RsParameters) << (SR_WIDTH - RS_WIDTH);
    assign selected_image = mode ? rs_aligned : sc_aligned;
    assign shifted        = shift_reg << WORD_WIDTH;
    assign target_words   = mode ? RS_TARGET : SC_TARGET;
    assign next_count     = word_count + CW'(1);
    assign write_en       = (state == WRITE) && !bus.FifoFull;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            mode       <= 1'b0;
            shift_reg  <= '0;
            data       <= '0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mode  <= bus.ModeSelect;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg  <= selected_image;
                    data       <= selected_image[SR_WIDTH-1 -: WORD_WIDTH];
                    word_count <= '0;
                    state      <= WRITE;
                end
                WRITE: begin
                    // A stalled word stays on FifoData until the FIFO accepts it.
                    if (write_en) begin
                        shift_reg  <= shifted;
                        data       <= shifted[SR_WIDTH-1 -: WORD_WIDTH];
                        word_count <= next_count;
                        if (next_count == target_words) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.FifoWriteEn = write_en;
    assign bus.FifoData    = data;
    assign bus.Busy        = (state != IDLE);
    assign bus.Done        = (state == DONE);
    assign bus.WordCount   = word_count;
endmodule

// File: tb/tb_parameter_word_serializer.sv
// Scoreboard bench for parameter_word_serializer: default build plus a 20-bit
// slow-control build for the partial-final-word case.
module tb_parameter_word_serializer;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [591:0]  sc_img = '0;
    logic [19:0]   sc20_img = '0;
    logic [63:0]   rs_img = '0;

    int            errors = 0;
    int            checks = 0;
    logic [15:0]   exp_q[$];
    logic [15:0]   exp_word;

    parameter_word_serializer_if bus ();
    parameter_word_serializer_if #(.SC_WIDTH(20)) bus20 ();

    parameter_word_serializer dut (
        .Clk          (clk),
        .reset        (reset),
        .ScParameters (sc_img),
        .RsParameters (rs_img),
        .bus          (bus)
    );

    parameter_word_serializer #(.SC_WIDTH(20)) dut20 (
        .Clk          (clk),
        .reset        (reset),
        .ScParameters (sc20_img),
        .RsParameters (rs_img),
        .bus          (bus20)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.FifoWriteEn !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: we=%b busy=%b done=%b expected 0 0 0",
                     bus.FifoWriteEn, bus.Busy, bus.Done);
        end
        checks++;
        if (bus.FifoData !== 16'h0 || bus.WordCount !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: data=%h count=%0d expected 0000 0", bus.FifoData, bus.WordCount);
        end
        checks++;
        if (bus20.FifoWriteEn !== 1'b0 || bus20.Busy !== 1'b0 || bus20.WordCount !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_dut20: we=%b busy=%b count=%0d expected 0 0 0",
                     bus20.FifoWriteEn, bus20.Busy, bus20.WordCount);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Full slow-control transfer; also reused after the mid-transfer reset.
    task automatic test_sc_full();
        logic [591:0] img;
        int writes = 0;
        int first_write = -1;
        int done_at = -1;
        logic [5:0] count_at_done = '0;
        for (int i = 0; i < 37; i++) img[i*16 +: 16] = 16'($urandom);
        img[591:576] = 16'hFA5E;
        exp_q.delete();
        for (int i = 0; i < 37; i++) exp_q.push_back(img[591-16*i -: 16]);
        sc_img = img;
        bus.ModeSelect = 1'b0;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int cyc = 0; cyc < 80 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (bus.FifoWriteEn) begin
                if (first_write < 0) first_write = cyc;
                writes++;
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (bus.FifoData !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL sc_word%0d: got %h expected %h", writes, bus.FifoData, exp_word);
                end
            end
            if (bus.Done) begin
                done_at = cyc;
                count_at_done = bus.WordCount;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first_write !== 1 || writes !== 37 || done_at !== 38) begin
            errors++;
            $display("[TB] FAIL sc_timing: first=%0d writes=%0d done_at=%0d expected 1 37 38",
                     first_write, writes, done_at);
        end
        checks++;
        if (count_at_done !== 6'd37 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL sc_count: count=%0d left=%0d expected 37 0", count_at_done, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.WordCount !== 6'd37) begin
            errors++;
            $display("[TB] FAIL sc_after: done=%b busy=%b count=%0d expected 0 0 37",
                     bus.Done, bus.Busy, bus.WordCount);
        end
        @(posedge clk); #1;
    endtask

    // Read-scope transfer with optional Start/ModeSelect disturbance during WRITE.
    task automatic run_rs(input bit disturb, input string tag);
        int writes = 0;
        int dones = 0;
        int done_at = -1;
        exp_q.delete();
        rs_img = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back(16'h0123);
        exp_q.push_back(16'h4567);
        exp_q.push_back(16'h89AB);
        exp_q.push_back(16'hCDEF);
        bus.ModeSelect = 1'b1;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.FifoWriteEn) begin
                writes++;
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (bus.FifoData !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL %s_word%0d: got %h expected %h", tag, writes, bus.FifoData, exp_word);
                end
            end
            if (bus.Done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
            bus.Start = disturb && (cyc == 1);
            if (disturb && cyc == 1) begin
                bus.ModeSelect = 1'b0;
                rs_img = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end
        checks++;
        if (writes !== 4 || dones !== 1 || done_at !== 5) begin
            errors++;
            $display("[TB] FAIL %s_timing: writes=%0d dones=%0d done_at=%0d expected 4 1 5",
                     tag, writes, dones, done_at);
        end
        checks++;
        if (bus.WordCount !== 6'd4 || bus.Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_final: count=%0d busy=%b expected 4 0", tag, bus.WordCount, bus.Busy);
        end
    endtask

    task automatic test_rs_image();
        run_rs(1'b0, "rs");
    endtask

    task automatic test_start_ignored();
        run_rs(1'b1, "ignore");
    endtask

    task automatic test_backpressure();
        int writes = 0;
        int full_cycles = 0;
        int done_at = -1;
        exp_q.delete();
        rs_img = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back(16'h0123);
        exp_q.push_back(16'h4567);
        exp_q.push_back(16'h89AB);
        exp_q.push_back(16'hCDEF);
        bus.ModeSelect = 1'b1;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int cyc = 0; cyc < 30 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (bus.FifoFull) begin
                checks++;
                if (bus.FifoWriteEn !== 1'b0 || bus.FifoData !== 16'h89AB) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: we=%b data=%h expected 0 89ab", bus.FifoWriteEn, bus.FifoData);
                end
            end
            if (bus.FifoWriteEn) begin
                writes++;
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (bus.FifoData !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL bp_word%0d: got %h expected %h", writes, bus.FifoData, exp_word);
                end
            end
            if (bus.Done) done_at = cyc;
            @(posedge clk); #1;
            if (writes == 2 && full_cycles < 5) begin
                bus.FifoFull = 1'b1;
                full_cycles++;
            end else begin
                bus.FifoFull = 1'b0;
            end
        end
        bus.FifoFull = 1'b0;
        checks++;
        if (writes !== 4 || done_at !== 10 || full_cycles !== 5) begin
            errors++;
            $display("[TB] FAIL bp_timing: writes=%0d done_at=%0d stalls=%0d expected 4 10 5",
                     writes, done_at, full_cycles);
        end
    endtask

    task automatic test_partial_word();
        int writes = 0;
        int done_at = -1;
        logic [2:0] count_at_done = '0;
        exp_q.delete();
        sc20_img = 20'hABCDE;
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'hE000);
        bus20.ModeSelect = 1'b0;
        bus20.Start = 1'b1;
        @(posedge clk); #1;
        bus20.Start = 1'b0;
        for (int cyc = 0; cyc < 20 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (bus20.FifoWriteEn) begin
                writes++;
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (bus20.FifoData !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL sc20_word%0d: got %h expected %h", writes, bus20.FifoData, exp_word);
                end
            end
            if (bus20.Done) begin
                done_at = cyc;
                count_at_done = bus20.WordCount;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (writes !== 2 || done_at !== 3 || count_at_done !== 3'd2) begin
            errors++;
            $display("[TB] FAIL sc20_timing: writes=%0d done_at=%0d count=%0d expected 2 3 2",
                     writes, done_at, count_at_done);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int writes = 0;
        int dones = 0;
        for (int i = 0; i < 37; i++) sc_img[i*16 +: 16] = 16'($urandom);
        bus.ModeSelect = 1'b0;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int cyc = 0; cyc < 40 && writes < 10; cyc++) begin
            @(negedge clk);
            if (bus.FifoWriteEn) writes++;
            if (bus.Done) dones++;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (writes !== 10 || bus.FifoWriteEn !== 1'b0 || bus.Busy !== 1'b0 || bus.WordCount !== 6'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: writes=%0d we=%b busy=%b count=%0d expected 10 0 0 0",
                     writes, bus.FifoWriteEn, bus.Busy, bus.WordCount);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: spurious done/busy cycles=%0d expected 0", dones);
        end
        test_sc_full();
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.ModeSelect = 1'b0;
        bus.FifoFull = 1'b0;
        bus20.Start = 1'b0;
        bus20.ModeSelect = 1'b0;
        bus20.FifoFull = 1'b0;
        test_reset();
        test_sc_full();
        test_rs_image();
        test_backpressure();
        test_partial_word();
        test_start_ignored();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
